// File: rtl/mod_mult_p256_pipe.sv
// mod_mult_p256_pipe: fully pipelined Q = (Xin * Yin) mod p for the NIST P-256 prime.
// A new operand pair is accepted every clock. Results come out in issue order,
// 4 edges after the sampling edge.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; clears the valid pipeline, Q and out_valid
//   in_valid   qualifies Xin/Yin on this edge
//   Xin, Yin   256-bit unsigned operands (any value, need not be < p)
//   Q          registered residue, always < p; holds while no valid result arrives
//   out_valid  registered; one pulse per accepted input
module mod_mult_p256_pipe #(
  parameter int unsigned  LATENCY = 4,
  parameter logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [255:0] Xin,
  input  logic [255:0] Yin,
  output logic [255:0] Q,
  output logic         out_valid
);

  localparam int unsigned W      = 256;
  localparam int unsigned PW     = 2 * W;
  localparam int unsigned WORD   = 32;
  localparam int unsigned NWORDS = PW / WORD;
  // Solinas sum lies in (-2^258, 2^259); 8 extra bits leave margin plus sign.
  localparam int unsigned QW     = 8;
  localparam int unsigned RW     = W + QW;

  localparam logic [WORD-1:0]      Z     = '0;
  localparam logic signed [RW-1:0] P_EXT = RW'(P);

  // Pipeline registers
  logic [W-1:0]           x1;
  logic [W-1:0]           y1;
  logic [PW-1:0]          prod2;
  logic signed [RW-1:0]   acc3;
  logic signed [RW-1:0]   fold4;
  logic [LATENCY-1:0]     vld;

  // Combinational stage outputs
  logic [WORD-1:0]        c [NWORDS];
  logic [W-1:0]           t, s1, s2, s3, s4, d1, d2, d3, d4;
  logic [RW-1:0]          pos_sum;
  logic [RW-1:0]          neg_sum;
  logic signed [RW-1:0]   acc_nxt;
  logic signed [QW-1:0]   q_hi;
  logic signed [RW-1:0]   q_ext;
  logic signed [RW-1:0]   fold_nxt;
  logic [W-1:0]           q_nxt;

  // Valid pipeline and output register; only these carry reset
  always_ff @(posedge clock) begin
    if (reset) begin
      vld       <= '0;
      out_valid <= 1'b0;
      Q         <= '0;
    end else begin
      vld       <= {vld[LATENCY-2:0], in_valid};
      out_valid <= vld[LATENCY-1];
      if (vld[LATENCY-1]) begin
        Q <= q_nxt;
      end
    end
  end

  // Datapath registers; contents are don't-care whenever the matching valid bit is low
  always_ff @(posedge clock) begin
    x1    <= Xin;
    y1    <= Yin;
    prod2 <= PW'(x1) * PW'(y1);
    acc3  <= acc_nxt;
    fold4 <= fold_nxt;
  end

  // Split the product into 32-bit words c0 (least significant) .. c15
  always_comb begin
    for (int unsigned i = 0; i < NWORDS; i++) begin
      c[i] = prod2[i*WORD +: WORD];
    end
  end

  // Solinas word maps, most-significant word first
  always_comb begin
    t  = {c[7],  c[6],  c[5],  c[4],  c[3],  c[2],  c[1],  c[0]};
    s1 = {c[15], c[14], c[13], c[12], c[11], Z,     Z,     Z};
    s2 = {Z,     c[15], c[14], c[13], c[12], Z,     Z,     Z};
    s3 = {c[15], c[14], Z,     Z,     Z,     c[10], c[9],  c[8]};
    s4 = {c[8],  c[13], c[15], c[14], c[13], c[11], c[10], c[9]};
    d1 = {c[10], c[8],  Z,     Z,     Z,     c[13], c[12], c[11]};
    d2 = {c[11], c[9],  Z,     Z,     c[15], c[14], c[13], c[12]};
    d3 = {c[12], Z,     c[10], c[9],  c[8],  c[15], c[14], c[13]};
    d4 = {c[13], Z,     c[11], c[10], c[9],  Z,     c[15], c[14]};
  end

  // T + 2S1 + 2S2 + S3 + S4 - D1 - D2 - D3 - D4, congruent to the product mod p
  always_comb begin
    pos_sum = RW'(t) + (RW'(s1) << 1) + (RW'(s2) << 1) + RW'(s3) + RW'(s4);
    neg_sum = RW'(d1) + RW'(d2) + RW'(d3) + RW'(d4);
    acc_nxt = signed'(pos_sum - neg_sum);
  end

  // Coarse fold: with k = floor(acc / 2^256), acc - k*p = low + k*(2^256 - p).
  // 2^256 - p = 2^224 - 2^192 - 2^96 + 1, so k*(2^256 - p) is three shifts and adds.
  // The result lands in [-8*(2^256-p), 2^256 + 8*(2^256-p)), within one p of [0, p).
  always_comb begin
    q_hi     = acc3[RW-1:W];
    q_ext    = {{(RW-QW){q_hi[QW-1]}}, q_hi};
    fold_nxt = signed'(RW'(acc3[W-1:0])) + (q_ext <<< 224) - (q_ext <<< 192)
               - (q_ext <<< 96) + q_ext;
  end

  // Final single-step correction into [0, p)
  always_comb begin
    q_nxt = fold4[W-1:0];
    if (fold4[RW-1]) begin
      q_nxt = W'(fold4 + P_EXT);
    end else if (fold4 >= P_EXT) begin
      q_nxt = W'(fold4 - P_EXT);
    end
  end

endmodule

// File: tb/tb_mod_mult_p256_pipe.sv
// Scoreboard bench for mod_mult_p256_pipe: stimulus pushes expected residues,
// a negedge monitor pops and compares them when out_valid is seen.
module tb_mod_mult_p256_pipe;

  localparam logic [255:0] P    = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] ALL1 = '1;
  localparam int unsigned  LAT  = 4;

  typedef struct packed {
    logic [255:0] q;
    int unsigned  cyc;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [255:0] Xin;
  logic [255:0] Yin;
  logic [255:0] Q;
  logic         out_valid;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  logic         rst_seen = 1'b0;
  bit           started = 1'b0;
  logic [255:0] last_q = '0;

  mod_mult_p256_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .Xin       (Xin),
    .Yin       (Yin),
    .Q         (Q),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic logic [255:0] ref_mod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] pr;
    pr = {256'b0, x} * {256'b0, y};
    pr = pr % {256'b0, P};
    return pr[255:0];
  endfunction

  function automatic logic [255:0] rand256(input bit force_high);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    if (force_high) r[255:224] = 32'hFFFFFFFF;
    return r;
  endfunction

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: compare outputs against the scoreboard on every falling edge
  always @(negedge clock) begin
    exp_t e;
    if (rst_seen) begin
      started = 1'b1;
      check256("reset_q", Q, '0);
      check_int("reset_out_valid", longint'(out_valid), 0);
      sb.delete();
      last_q = '0;
    end else if (started) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_valid=1 with Q=%h required no result", Q);
        end else begin
          e = sb.pop_front();
          check256("result_q", Q, e.q);
          check_int("latency", longint'(cyc - e.cyc), longint'(LAT));
          last_q = e.q;
        end
      end else begin
        check_int("idle_out_valid", longint'(out_valid), 0);
        check256("hold_q", Q, last_q);
        if (sb.size() > 0 && cyc > sb[0].cyc + LAT) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_out: got no result at cycle %0d required one for issue cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [255:0] x, input logic [255:0] y, input logic [255:0] q);
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1;
    Xin = x;
    Yin = y;
    e.q = q;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic issue_model(input logic [255:0] x, input logic [255:0] y);
    issue(x, y, ref_mod(x, y));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
      Xin = rand256(1'b0);
      Yin = rand256(1'b0);
    end
  endtask

  task automatic pulse_reset(input logic with_valid);
    @(negedge clock);
    reset = 1'b1;
    in_valid = with_valid;
    Xin = rand256(1'b0);
    Yin = rand256(1'b0);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    int budget;

    // Reset held one cycle with in_valid high: that input must be dropped
    reset = 1'b1;
    in_valid = 1'b1;
    Xin = 256'd7;
    Yin = 256'd9;
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    idle(5);

    // Small operands with hand-computed residues
    issue(256'd2, 256'd3, 256'd6);
    issue(P - 256'd1, P - 256'd1, 256'd1);
    issue(P, 256'd5, 256'd0);
    idle(5);

    // Back-to-back random stream over the full 256-bit range
    for (int i = 0; i < 10; i++) begin
      a = rand256(i % 3 == 0);
      b = rand256(i % 4 == 1);
      issue_model(a, b);
    end
    idle(5);

    // Extremes
    issue_model(ALL1, ALL1);
    issue(256'd0, ALL1, 256'd0);
    issue(ALL1, 256'd0, 256'd0);
    issue_model(P, P);
    idle(5);

    // Bubbles: valid, idle, idle, valid
    issue_model(rand256(1'b1), rand256(1'b0));
    idle(2);
    issue_model(rand256(1'b0), rand256(1'b1));
    idle(5);

    // Mid-stream reset discards three in-flight results
    for (int i = 0; i < 3; i++) issue_model(rand256(1'b0), rand256(1'b0));
    pulse_reset(1'b0);
    idle(2);
    issue_model(rand256(1'b1), rand256(1'b1));
    idle(2);

    // Drain with a bounded wait
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
